// File: rtl/cop_dispatcher_pkg.sv
// Shared constants and helpers for the sasanqua coprocessor dispatch blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cop_dispatcher_pkg;

   localparam int COP_OPCODE_W = 17;   // {opcode, funct3, funct7}
   localparam int COP_SEL_W    = 2;    // implementation index width
   localparam int COP_MAX      = 4;    // most implementations one dispatcher serves
   localparam int COP_EXC_W    = 4;    // exception-code width
   localparam int COP_RD_W     = 5;    // destination register index width
   localparam int COP_DATA_W   = 32;   // register write data width
   localparam int COP_CNT_W    = 32;   // retired-instruction counter width

   // Fixed-priority pick: lowest index with its request set, 0 when none is set.
   function automatic logic [COP_SEL_W-1:0] cop_first_set(input logic [COP_MAX-1:0] req);
      logic [COP_SEL_W-1:0] idx;
      idx = '0;
      for (int i = COP_MAX - 1; i >= 0; i--) begin
         if (req[i]) idx = COP_SEL_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/cop_dispatch_counter.sv
// Saturating retired-instruction counter, one per coprocessor implementation.
// Latency: count reflects an increment one edge after inc is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, rst (sync, active-high), inc (count enable), count (current value).
module cop_dispatch_counter
   import cop_dispatcher_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   output logic [COP_CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/cop_dispatcher.sv
// Routes the core's Check/Ready/Exec coprocessor port to one of COP_NUM (1..4) implementations.
// Latency: Check to Exec is exactly 2 cycles; result mux, allow and conflict are combinational.
// Backpressure: none; stages advance every edge, FLUSH kills Ready/Exec ops, RST beats FLUSH.
// Ports: CLK/RST/FLUSH control; C_* Check side toward the core; COP_C_ACCEPT per-implementation
//        accepts; E_ALLOW/COP_E_ALLOW exec gating; COP_E_* flattened per-implementation results;
//        E_* muxed result, E_SEL owner index, E_CONFLICT; CNT_SEL/CNT_VALUE counter readback.
module cop_dispatcher
   import cop_dispatcher_pkg::*;
#(
   parameter int COP_NUM = 2,
   parameter int SEL_W   = COP_SEL_W
)(
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          FLUSH,
   input  logic [COP_OPCODE_W-1:0]       C_OPCODE,
   output logic                          C_ACCEPT,
   input  logic [COP_NUM-1:0]            COP_C_ACCEPT,
   input  logic                          E_ALLOW,
   output logic [COP_NUM-1:0]            COP_E_ALLOW,
   input  logic [COP_NUM-1:0]            COP_E_VALID,
   input  logic [COP_NUM-1:0]            COP_E_REG_W_EN,
   input  logic [COP_RD_W*COP_NUM-1:0]   COP_E_REG_W_RD,
   input  logic [COP_DATA_W*COP_NUM-1:0] COP_E_REG_W_DATA,
   input  logic [COP_NUM-1:0]            COP_E_EXC_EN,
   input  logic [COP_EXC_W*COP_NUM-1:0]  COP_E_EXC_CODE,
   output logic                          E_VALID,
   output logic                          E_REG_W_EN,
   output logic [COP_RD_W-1:0]           E_REG_W_RD,
   output logic [COP_DATA_W-1:0]         E_REG_W_DATA,
   output logic                          E_EXC_EN,
   output logic [COP_EXC_W-1:0]          E_EXC_CODE,
   output logic [SEL_W-1:0]              E_SEL,
   output logic                          E_CONFLICT,
   input  logic [SEL_W-1:0]              CNT_SEL,
   output logic [COP_CNT_W-1:0]          CNT_VALUE
);

   // The opcode only travels to monitors; it plays no part in dispatch.
   logic unused_opcode;
   assign unused_opcode = ^C_OPCODE;

   // ---------------------------------------------------------------
   // Check stage
   // ---------------------------------------------------------------
   logic [SEL_W-1:0] winner;

   assign C_ACCEPT = |COP_C_ACCEPT;
   assign winner   = SEL_W'(cop_first_set(COP_MAX'(COP_C_ACCEPT)));

   // ---------------------------------------------------------------
   // Ready / Exec tracking registers
   // ---------------------------------------------------------------
   logic             r_valid;
   logic             e_valid;
   logic [SEL_W-1:0] r_sel;
   logic [SEL_W-1:0] e_sel;

   // Only the valid bits are flushed; the sel registers keep tracking so the
   // Exec owner index stays a pure 2-cycle delay of the Check winner.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_valid <= 1'b0;
         e_valid <= 1'b0;
         r_sel   <= '0;
         e_sel   <= '0;
      end else begin
         r_valid <= C_ACCEPT & ~FLUSH;
         e_valid <= r_valid & ~FLUSH;
         r_sel   <= winner;
         e_sel   <= r_sel;
      end
   end

   // ---------------------------------------------------------------
   // Exec stage: pick the owning implementation's signals
   // ---------------------------------------------------------------
   logic                  sel_valid;
   logic                  sel_w_en;
   logic [COP_RD_W-1:0]   sel_w_rd;
   logic [COP_DATA_W-1:0] sel_w_data;
   logic                  sel_exc_en;
   logic [COP_EXC_W-1:0]  sel_exc_code;

   // Comparing against each index keeps the lookup in range for any COP_NUM.
   always_comb begin
      sel_valid    = 1'b0;
      sel_w_en     = 1'b0;
      sel_w_rd     = '0;
      sel_w_data   = '0;
      sel_exc_en   = 1'b0;
      sel_exc_code = '0;
      for (int i = 0; i < COP_NUM; i++) begin
         if (e_sel == SEL_W'(i)) begin
            sel_valid    = COP_E_VALID[i];
            sel_w_en     = COP_E_REG_W_EN[i];
            sel_w_rd     = COP_E_REG_W_RD[COP_RD_W*i +: COP_RD_W];
            sel_w_data   = COP_E_REG_W_DATA[COP_DATA_W*i +: COP_DATA_W];
            sel_exc_en   = COP_E_EXC_EN[i];
            sel_exc_code = COP_E_EXC_CODE[COP_EXC_W*i +: COP_EXC_W];
         end
      end
   end

   logic exec_allowed;
   assign exec_allowed = E_ALLOW & e_valid;

   always_comb begin
      COP_E_ALLOW = '0;
      for (int i = 0; i < COP_NUM; i++) begin
         COP_E_ALLOW[i] = exec_allowed & (e_sel == SEL_W'(i));
      end
   end

   // Result fields follow ownership alone; E_ALLOW only qualifies valid/conflict.
   assign E_VALID      = exec_allowed & sel_valid;
   assign E_CONFLICT   = exec_allowed & ~sel_valid;
   assign E_REG_W_EN   = e_valid & sel_w_en;
   assign E_REG_W_RD   = e_valid ? sel_w_rd     : '0;
   assign E_REG_W_DATA = e_valid ? sel_w_data   : '0;
   assign E_EXC_EN     = e_valid & sel_exc_en;
   assign E_EXC_CODE   = e_valid ? sel_exc_code : '0;
   assign E_SEL        = e_sel;

   // ---------------------------------------------------------------
   // Per-implementation retired counters
   // ---------------------------------------------------------------
   logic [COP_CNT_W-1:0] cnt [COP_NUM];

   for (genvar g = 0; g < COP_NUM; g++) begin : g_cnt
      cop_dispatch_counter u_cnt (
         .clk   (CLK),
         .rst   (RST),
         .inc   (E_VALID && (e_sel == SEL_W'(g))),
         .count (cnt[g])
      );
   end

   // Indices beyond the populated implementations read as zero.
   always_comb begin
      CNT_VALUE = '0;
      for (int i = 0; i < COP_NUM; i++) begin
         if (CNT_SEL == SEL_W'(i)) CNT_VALUE = cnt[i];
      end
   end

endmodule

// File: tb/tb_cop_dispatcher.sv
// Self-checking bench for cop_dispatcher with two implementations attached.
// Latency: checks sample 2 time units after each rising edge.
// Backpressure: n/a.
module tb_cop_dispatcher;

   localparam int N = 2;

   logic        clk;
   logic        rst;
   logic        flush;
   logic [16:0] c_opcode;
   logic        c_accept;
   logic [N-1:0] cop_c_accept;
   logic        e_allow;
   logic [N-1:0] cop_e_allow;
   logic [N-1:0] cop_e_valid;
   logic [N-1:0] cop_e_reg_w_en;
   logic [5*N-1:0] cop_e_reg_w_rd;
   logic [32*N-1:0] cop_e_reg_w_data;
   logic [N-1:0] cop_e_exc_en;
   logic [4*N-1:0] cop_e_exc_code;
   logic        e_valid;
   logic        e_reg_w_en;
   logic [4:0]  e_reg_w_rd;
   logic [31:0] e_reg_w_data;
   logic        e_exc_en;
   logic [3:0]  e_exc_code;
   logic [1:0]  e_sel;
   logic        e_conflict;
   logic [1:0]  cnt_sel;
   logic [31:0] cnt_value;

   int checks = 0;
   int failures = 0;

   cop_dispatcher #(.COP_NUM(N), .SEL_W(2)) dut (
      .CLK(clk), .RST(rst), .FLUSH(flush), .C_OPCODE(c_opcode), .C_ACCEPT(c_accept),
      .COP_C_ACCEPT(cop_c_accept), .E_ALLOW(e_allow), .COP_E_ALLOW(cop_e_allow),
      .COP_E_VALID(cop_e_valid), .COP_E_REG_W_EN(cop_e_reg_w_en), .COP_E_REG_W_RD(cop_e_reg_w_rd),
      .COP_E_REG_W_DATA(cop_e_reg_w_data), .COP_E_EXC_EN(cop_e_exc_en),
      .COP_E_EXC_CODE(cop_e_exc_code), .E_VALID(e_valid), .E_REG_W_EN(e_reg_w_en),
      .E_REG_W_RD(e_reg_w_rd), .E_REG_W_DATA(e_reg_w_data), .E_EXC_EN(e_exc_en),
      .E_EXC_CODE(e_exc_code), .E_SEL(e_sel), .E_CONFLICT(e_conflict),
      .CNT_SEL(cnt_sel), .CNT_VALUE(cnt_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // History of the inputs seen at each edge; an op accepted in cycle c owns
   // Exec in cycle c+2 unless RST or FLUSH was high in cycle c or c+1.
   logic [N-1:0] h_acc [8];
   bit           h_rst [8];
   bit           h_fl  [8];
   int           cyc = 2;
   longint unsigned cnt_m [N];

   initial begin
      for (int i = 0; i < 8; i++) begin
         h_acc[i] = '0; h_rst[i] = 1'b1; h_fl[i] = 1'b0;
      end
      for (int i = 0; i < N; i++) cnt_m[i] = 0;
   end

   function automatic int lowest_set(input logic [N-1:0] v);
      int r = 0;
      for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
      return r;
   endfunction

   function automatic void exp_exec(input int c, output bit vld, output int sel);
      int a = (c - 2) & 7;
      int b = (c - 1) & 7;
      vld = (h_acc[a] != '0) && !h_rst[a] && !h_rst[b] && !h_fl[a] && !h_fl[b];
      sel = (h_rst[a] || h_rst[b]) ? 0 : lowest_set(h_acc[a]);
   endfunction

   always @(posedge clk) begin
      bit v;
      int s;
      exp_exec(cyc, v, s);
      if (rst) begin
         for (int i = 0; i < N; i++) cnt_m[i] = 0;
      end else if (v && e_allow && cop_e_valid[s] && cnt_m[s] < 64'hFFFF_FFFF) begin
         cnt_m[s] = cnt_m[s] + 1;
      end
      h_acc[cyc & 7] = cop_c_accept;
      h_rst[cyc & 7] = rst;
      h_fl[cyc & 7]  = flush;
      cyc = cyc + 1;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      flush = 0; c_opcode = '0; cop_c_accept = '0; e_allow = 0; cop_e_valid = '0;
      cop_e_reg_w_en = '0; cop_e_reg_w_rd = '0; cop_e_reg_w_data = '0;
      cop_e_exc_en = '0; cop_e_exc_code = '0; cnt_sel = '0;
   endtask

   task automatic do_reset();
      rst = 1; clear_inputs();
      tick(); tick();
      rst = 0;
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1; clear_inputs();
      cop_c_accept = 2'b11; e_allow = 1; cop_e_valid = 2'b11; cop_e_reg_w_en = 2'b11;
      cop_e_reg_w_data = {32'hDEAD_BEEF, 32'hCAFE_F00D}; cop_e_exc_en = 2'b11;
      tick(); tick(); #1;
      checks++; if (c_accept !== 1'b1) begin failures++; $display("FAIL reset_c_accept got=%0b exp=1", c_accept); end
      checks++; if (cop_e_allow !== 2'b00) begin failures++; $display("FAIL reset_cop_e_allow got=%b exp=00", cop_e_allow); end
      checks++; if (e_valid !== 1'b0 || e_conflict !== 1'b0) begin failures++; $display("FAIL reset_valid_conflict got=%0b%0b exp=00", e_valid, e_conflict); end
      checks++; if (e_reg_w_data !== 32'h0 || e_reg_w_en !== 1'b0 || e_exc_en !== 1'b0 || e_sel !== 2'd0) begin
         failures++; $display("FAIL reset_result data=%h en=%0b exc=%0b sel=%0d exp=all zero", e_reg_w_data, e_reg_w_en, e_exc_en, e_sel); end
      checks++; if (cnt_value !== 32'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", cnt_value); end
      rst = 0;
      #1;
      checks++; if (e_valid !== 1'b0 || cop_e_allow !== 2'b00 || e_reg_w_data !== 32'h0) begin
         failures++; $display("FAIL reset_first_cycle valid=%0b allow=%b data=%h exp=0,00,0", e_valid, cop_e_allow, e_reg_w_data); end
      clear_inputs();
   endtask

   task automatic test_single_issue();
      do_reset();
      cop_c_accept = 2'b10; #1;
      checks++; if (c_accept !== 1'b1) begin failures++; $display("FAIL single_c_accept got=%0b exp=1", c_accept); end
      tick(); cop_c_accept = 2'b00;
      tick(); e_allow = 1; cop_e_valid = 2'b10; cop_e_reg_w_data = {32'h0000_0007, 32'h0000_0099};
      #1;
      checks++; if (cop_e_allow !== 2'b10) begin failures++; $display("FAIL single_cop_e_allow got=%b exp=10", cop_e_allow); end
      checks++; if (e_sel !== 2'd1) begin failures++; $display("FAIL single_e_sel got=%0d exp=1", e_sel); end
      checks++; if (e_valid !== 1'b1) begin failures++; $display("FAIL single_e_valid got=%0b exp=1", e_valid); end
      checks++; if (e_reg_w_data !== 32'h7) begin failures++; $display("FAIL single_data got=%h exp=7", e_reg_w_data); end
      tick(); clear_inputs(); cnt_sel = 2'd1; #1;
      checks++; if (cnt_value !== 32'd1) begin failures++; $display("FAIL single_cnt1 got=%0d exp=1", cnt_value); end
   endtask

   task automatic test_priority();
      do_reset();
      cop_c_accept = 2'b11;
      tick(); cop_c_accept = 2'b00;
      tick(); e_allow = 1; cop_e_valid = 2'b11;
      cop_e_reg_w_data = {32'h2222_2222, 32'h1111_1111}; cop_e_reg_w_rd = {5'd9, 5'd3};
      #1;
      checks++; if (cop_e_allow !== 2'b01) begin failures++; $display("FAIL prio_cop_e_allow got=%b exp=01", cop_e_allow); end
      checks++; if (e_sel !== 2'd0) begin failures++; $display("FAIL prio_e_sel got=%0d exp=0", e_sel); end
      checks++; if (e_reg_w_data !== 32'h1111_1111 || e_reg_w_rd !== 5'd3) begin
         failures++; $display("FAIL prio_data got=%h/%0d exp=11111111/3", e_reg_w_data, e_reg_w_rd); end
      tick(); clear_inputs(); cnt_sel = 2'd1; #1;
      checks++; if (cnt_value !== 32'd0) begin failures++; $display("FAIL prio_cnt1 got=%0d exp=0", cnt_value); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      cop_c_accept = 2'b01;
      tick(); cop_c_accept = 2'b10;
      tick(); cop_c_accept = 2'b00; e_allow = 1; cop_e_valid = 2'b11; #1;
      checks++; if (e_sel !== 2'd0 || e_valid !== 1'b1) begin failures++; $display("FAIL b2b_first sel=%0d valid=%0b exp=0,1", e_sel, e_valid); end
      tick(); #1;
      checks++; if (e_sel !== 2'd1 || e_valid !== 1'b1) begin failures++; $display("FAIL b2b_second sel=%0d valid=%0b exp=1,1", e_sel, e_valid); end
      tick(); clear_inputs(); #1;
      checks++; if (cnt_value !== 32'd1) begin failures++; $display("FAIL b2b_cnt0 got=%0d exp=1", cnt_value); end
      cnt_sel = 2'd1; #1;
      checks++; if (cnt_value !== 32'd1) begin failures++; $display("FAIL b2b_cnt1 got=%0d exp=1", cnt_value); end
   endtask

   task automatic test_flush();
      do_reset();
      // Op in Ready is killed by FLUSH.
      cop_c_accept = 2'b01;
      tick(); cop_c_accept = 2'b00; flush = 1;
      tick(); flush = 0; e_allow = 1; cop_e_valid = 2'b11; cop_e_reg_w_en = 2'b11;
      cop_e_reg_w_data = {32'hAAAA_0001, 32'hBBBB_0002}; cop_e_exc_en = 2'b11; cop_e_exc_code = 8'h5A;
      #1;
      checks++; if (e_valid !== 1'b0 || cop_e_allow !== 2'b00 || e_conflict !== 1'b0) begin
         failures++; $display("FAIL flush_ctrl valid=%0b allow=%b conflict=%0b exp=0,00,0", e_valid, cop_e_allow, e_conflict); end
      checks++; if (e_reg_w_data !== 32'h0 || e_reg_w_en !== 1'b0 || e_exc_en !== 1'b0 || e_exc_code !== 4'h0) begin
         failures++; $display("FAIL flush_result data=%h en=%0b exc=%0b code=%h exp=zero", e_reg_w_data, e_reg_w_en, e_exc_en, e_exc_code); end
      // Op already in Exec completes in the FLUSH cycle; the op behind it dies.
      cop_c_accept = 2'b01;
      tick(); cop_c_accept = 2'b10;
      tick(); cop_c_accept = 2'b00; flush = 1; #1;
      checks++; if (e_valid !== 1'b1 || e_sel !== 2'd0) begin failures++; $display("FAIL flush_same_cycle valid=%0b sel=%0d exp=1,0", e_valid, e_sel); end
      tick(); flush = 0; #1;
      checks++; if (e_valid !== 1'b0) begin failures++; $display("FAIL flush_ready_killed got=%0b exp=0", e_valid); end
      tick(); clear_inputs(); #1;
      checks++; if (cnt_value !== 32'd1) begin failures++; $display("FAIL flush_cnt0 got=%0d exp=1", cnt_value); end
   endtask

   task automatic test_conflict_gating();
      do_reset();
      cop_c_accept = 2'b01;
      tick(); cop_c_accept = 2'b00;
      tick(); e_allow = 1; cop_e_valid = 2'b10; #1;
      checks++; if (e_conflict !== 1'b1 || e_valid !== 1'b0 || cop_e_allow !== 2'b01) begin
         failures++; $display("FAIL conflict conflict=%0b valid=%0b allow=%b exp=1,0,01", e_conflict, e_valid, cop_e_allow); end
      tick(); #1;
      checks++; if (e_conflict !== 1'b0) begin failures++; $display("FAIL conflict_one_cycle got=%0b exp=0", e_conflict); end
      checks++; if (cnt_value !== 32'd0) begin failures++; $display("FAIL conflict_cnt0 got=%0d exp=0", cnt_value); end
      clear_inputs();
      cop_c_accept = 2'b10;
      tick(); cop_c_accept = 2'b00;
      tick(); e_allow = 0; cop_e_valid = 2'b10; cop_e_reg_w_en = 2'b10;
      cop_e_reg_w_data = {32'h1234_5678, 32'h8765_4321}; #1;
      checks++; if (cop_e_allow !== 2'b00 || e_valid !== 1'b0 || e_conflict !== 1'b0) begin
         failures++; $display("FAIL gate_ctrl allow=%b valid=%0b conflict=%0b exp=00,0,0", cop_e_allow, e_valid, e_conflict); end
      checks++; if (e_reg_w_data !== 32'h1234_5678 || e_reg_w_en !== 1'b1 || e_sel !== 2'd1) begin
         failures++; $display("FAIL gate_mux data=%h en=%0b sel=%0d exp=12345678,1,1", e_reg_w_data, e_reg_w_en, e_sel); end
      tick(); clear_inputs(); cnt_sel = 2'd1; #1;
      checks++; if (cnt_value !== 32'd0) begin failures++; $display("FAIL gate_cnt1 got=%0d exp=0", cnt_value); end
   endtask

   task automatic test_saturation();
      do_reset();
      force dut.g_cnt[0].u_cnt.count = 32'hFFFF_FFFE;
      cnt_m[0] = 64'hFFFF_FFFE;
      #1;
      release dut.g_cnt[0].u_cnt.count;
      cop_c_accept = 2'b01; e_allow = 1; cop_e_valid = 2'b11;
      for (int i = 0; i < 5; i++) tick();
      clear_inputs(); #1;
      checks++; if (cnt_value !== 32'hFFFF_FFFF) begin failures++; $display("FAIL saturate got=%h exp=ffffffff", cnt_value); end
   endtask

   task automatic test_reset_midpipe();
      do_reset();
      cop_c_accept = 2'b01;
      tick();
      tick(); cop_c_accept = 2'b00; e_allow = 1; cop_e_valid = 2'b11; rst = 1; #1;
      checks++; if (e_valid !== 1'b1) begin failures++; $display("FAIL midrst_before got=%0b exp=1", e_valid); end
      tick(); rst = 0; #1;
      checks++; if (e_valid !== 1'b0 || cop_e_allow !== 2'b00 || e_sel !== 2'd0) begin
         failures++; $display("FAIL midrst_pipe valid=%0b allow=%b sel=%0d exp=0,00,0", e_valid, cop_e_allow, e_sel); end
      checks++; if (cnt_value !== 32'd0) begin failures++; $display("FAIL midrst_cnt got=%0d exp=0", cnt_value); end
      clear_inputs();
   endtask

   task automatic test_random();
      bit v;
      int s;
      logic [N-1:0] exp_allow;
      logic [31:0] exp_cnt;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         tick();
         rst = ($urandom_range(0, 39) == 0);
         flush = ($urandom_range(0, 7) == 0);
         c_opcode = 17'($urandom);
         cop_c_accept = N'($urandom);
         e_allow = ($urandom_range(0, 3) != 0);
         cop_e_valid = N'($urandom);
         cop_e_reg_w_en = N'($urandom);
         cop_e_reg_w_rd = 10'($urandom);
         cop_e_reg_w_data = {$urandom, $urandom};
         cop_e_exc_en = N'($urandom);
         cop_e_exc_code = 8'($urandom);
         cnt_sel = 2'($urandom);
         #1;
         exp_exec(cyc, v, s);
         exp_allow = (e_allow && v) ? N'(1 << s) : '0;
         exp_cnt = (int'(cnt_sel) < N) ? 32'(cnt_m[cnt_sel]) : 32'h0;
         checks++; if (c_accept !== (|cop_c_accept)) begin failures++; $display("FAIL rnd_c_accept n=%0d got=%0b", n, c_accept); end
         checks++; if (cop_e_allow !== exp_allow) begin failures++; $display("FAIL rnd_cop_e_allow n=%0d got=%b exp=%b", n, cop_e_allow, exp_allow); end
         checks++; if (e_sel !== 2'(s)) begin failures++; $display("FAIL rnd_e_sel n=%0d got=%0d exp=%0d", n, e_sel, s); end
         checks++; if (e_valid !== (e_allow && v && cop_e_valid[s])) begin failures++; $display("FAIL rnd_e_valid n=%0d got=%0b", n, e_valid); end
         checks++; if (e_conflict !== (e_allow && v && !cop_e_valid[s])) begin failures++; $display("FAIL rnd_e_conflict n=%0d got=%0b", n, e_conflict); end
         checks++; if (e_reg_w_data !== (v ? cop_e_reg_w_data[32*s +: 32] : 32'h0)) begin
            failures++; $display("FAIL rnd_data n=%0d got=%h", n, e_reg_w_data); end
         checks++; if (e_reg_w_rd !== (v ? cop_e_reg_w_rd[5*s +: 5] : 5'h0) || e_reg_w_en !== (v && cop_e_reg_w_en[s])) begin
            failures++; $display("FAIL rnd_rd_en n=%0d got=%0d/%0b", n, e_reg_w_rd, e_reg_w_en); end
         checks++; if (e_exc_code !== (v ? cop_e_exc_code[4*s +: 4] : 4'h0) || e_exc_en !== (v && cop_e_exc_en[s])) begin
            failures++; $display("FAIL rnd_exc n=%0d got=%h/%0b", n, e_exc_code, e_exc_en); end
         checks++; if (cnt_value !== exp_cnt) begin failures++; $display("FAIL rnd_cnt n=%0d sel=%0d got=%0d exp=%0d", n, cnt_sel, cnt_value, exp_cnt); end
      end
      rst = 0;
      clear_inputs();
   endtask

   initial begin
      rst = 1;
      clear_inputs();
      test_reset();
      test_single_issue();
      test_priority();
      test_back_to_back();
      test_flush();
      test_conflict_gating();
      test_saturation();
      test_reset_midpipe();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cop_dispatcher.md
Name: cop_dispatcher

Overview:
- Sits between the core's coprocessor port and up to four coprocessor implementations (e.g. cop_rv32i_mini).
- Every implementation shares the three-phase Check / Ready / Exec interface.
- Arbitrates Check-phase acceptance by fixed priority and tracks the winner through the two registered pipeline stages.
- Gates E_ALLOW to the winning implementation only, muxes its Exec result back to the core, and keeps per-implementation retired-instruction counters.

Parameters:
- COP_NUM, 2: number of attached coprocessor implementations; legal range 1..4.
- SEL_W, 2: width of the implementation index; fixed at 2.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- FLUSH  in  1  kills the ops in the Ready and Exec stages at the next edge.
- C_OPCODE  in  17  Check opcode {opcode, funct3, funct7}; not used internally, forwarded to monitors only.
- C_ACCEPT  out  1  some implementation accepts C_OPCODE.
- COP_C_ACCEPT  in  COP_NUM  per-implementation Check accept.
- E_ALLOW  in  1  core permits Exec-stage completion this cycle.
- COP_E_ALLOW  out  COP_NUM  per-implementation allow; one-hot or zero.
- COP_E_VALID  in  COP_NUM  per-implementation Exec valid.
- COP_E_REG_W_EN  in  COP_NUM  per-implementation write enable.
- COP_E_REG_W_RD  in  5*COP_NUM  flattened; implementation i occupies [5i+4:5i].
- COP_E_REG_W_DATA  in  32*COP_NUM  flattened.
- COP_E_EXC_EN  in  COP_NUM.
- COP_E_EXC_CODE  in  4*COP_NUM  flattened.
- E_VALID  out  1  muxed Exec result is valid.
- E_REG_W_EN  out  1.
- E_REG_W_RD  out  5.
- E_REG_W_DATA  out  32.
- E_EXC_EN  out  1.
- E_EXC_CODE  out  4.
- E_SEL  out  2  index of the implementation owning the Exec stage.
- E_CONFLICT  out  1  selected implementation failed to assert valid while allowed.
- CNT_SEL  in  2  counter read index.
- CNT_VALUE  out  32  retired count of implementation CNT_SEL.

Behaviour:
- Check stage (combinational):
  - C_ACCEPT = OR of COP_C_ACCEPT.
  - Winner = lowest index with accept set; 0 if none.
- Ready stage (every edge):
  - r_valid <= C_ACCEPT; r_sel <= winner.
- Exec stage (every edge):
  - e_valid <= r_valid; e_sel <= r_sel.
  - Stages never stall. This matches the implementations, which also register each cycle unconditionally.
  - Latency from Check to Exec is exactly 2 cycles.
- FLUSH:
  - At the edge where FLUSH=1: r_valid <= 0 and e_valid <= 0. The sel registers update normally.
  - Outputs in the FLUSH cycle itself are unaffected.
  - RST has priority over FLUSH.
- Allow gating: COP_E_ALLOW[i] = E_ALLOW & e_valid & (e_sel==i).
- E_VALID = E_ALLOW & e_valid & COP_E_VALID[e_sel].
- Result muxing:
  - When e_valid=1, the E_REG_W_* and E_EXC_* outputs are the selected implementation's signals.
  - When e_valid=0 they are all 0. They do not depend on E_ALLOW.
- E_CONFLICT = E_ALLOW & e_valid & ~COP_E_VALID[e_sel]. Combinational; held for one cycle only.
- E_SEL = e_sel.
- Counters:
  - cnt[i] increments by 1 at the edge where E_VALID=1 and e_sel==i.
  - cnt[i] saturates at 32'hFFFF_FFFF and never wraps.
  - CNT_VALUE = cnt[CNT_SEL] combinationally; reads 0 if CNT_SEL >= COP_NUM.
- Reset values:
  - r_valid, e_valid, r_sel, e_sel and all counters are 0.
  - Therefore every output is 0 while RST is held and in the first cycle after release, except C_ACCEPT, which follows the inputs.
- Simultaneous accepts: lower index wins; higher-index implementations still advance their own internal stages but never receive allow.
- COP_NUM=1: the winner is always 0 and the muxes degenerate to wires.

Decomposition:
- Shared header, included by all sasanqua_cop blocks:
  - COP_OPCODE_W = 17, COP_SEL_W = 2, COP_MAX = 4.
  - Exception-code width 4.
- One sub-module, cop_dispatch_counter: 32-bit saturating counter with synchronous active-high reset and increment enable. Instantiated COP_NUM times.

Test Plan:
- Single issue: COP_C_ACCEPT=2'b10 at cycle 0, then 0 → C_ACCEPT=1 at cycle 0.
  - At cycle 2, with E_ALLOW=1 and COP_E_VALID[1]=1, REG_W_DATA[1]=32'h0000_0007: COP_E_ALLOW=2'b10, E_SEL=1, E_VALID=1, E_REG_W_DATA=32'h7.
  - cnt[1]=1 afterwards.
- Priority: both accepts at cycle 0 → at cycle 2, COP_E_ALLOW=2'b01, E_SEL=0, and implementation 1's data is ignored.
- Back-to-back: accept by cop0 at cycle 0 and cop1 at cycle 1 → E_SEL=0 at cycle 2, E_SEL=1 at cycle 3, both counters =1.
- Flush: accept at cycle 0, FLUSH=1 at cycle 1 → e_valid=0 at cycle 2, all E_* outputs =0, counters unchanged.
- Conflict and gating:
  - E_ALLOW=1, e_valid=1 and selected COP_E_VALID=0 → E_CONFLICT=1, E_VALID=0, no counter increment.
  - E_ALLOW=0 with e_valid=1 → COP_E_ALLOW=0, E_VALID=0, E_REG_W_DATA still muxed.
- Saturation and reset: force cnt[0]=32'hFFFF_FFFE and retire 3 ops → CNT_VALUE=32'hFFFF_FFFF.
  - Assert RST with an op mid-pipeline → next cycle e_valid=0, CNT_VALUE=0.
